// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer around a 1-bit ALU slice: LSB first, one bit per clock.
// Optional ovf_o output enabled by defining ALU_SERIAL_OVF_EN.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             zero_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_cin_o,
  output logic [3:0]       slice_sel_o,
  input  logic             slice_f_i,
  input  logic             slice_cout_i
`ifdef ALU_SERIAL_OVF_EN
  ,
  output logic             ovf_o
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sr_q, res_next, a_shr, a_shl;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             is_arith, last_bit, accept;

  assign is_arith = (op_q[3:2] == 2'b00);
  assign last_bit = (state_q == RUN) && (cnt_q == LAST);
  assign accept   = (state_q == IDLE) && start_i;
  assign res_next = {slice_f_i, sr_q[WIDTH-1:1]};
  // Pre-shifted copies of A make the shift drive a plain index by cnt.
  assign a_shr    = {1'b0, a_q[WIDTH-1:1]};
  assign a_shl    = {a_q[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        busy_o = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    slice_a_o   = 1'b0;
    slice_b_o   = 1'b0;
    slice_cin_o = 1'b0;
    slice_sel_o = 4'b0000;
    if (state_q == RUN) begin
      case (op_q[3:2])
        2'b10:   slice_a_o = a_shr[cnt_q];
        2'b11:   slice_a_o = a_shl[cnt_q];
        default: begin
          slice_sel_o = op_q;
          slice_a_o   = a_q[cnt_q];
          slice_b_o   = b_q[cnt_q];
          slice_cin_o = is_arith ? carry_q : 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sr_q     <= '0;
      result_o <= '0;
      cout_o   <= 1'b0;
      zero_o   <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
      ovf_o    <= 1'b0;
`endif
    end else if (accept) begin
      a_q     <= a_i;
      b_q     <= b_i;
      op_q    <= op_i;
      cnt_q   <= '0;
      carry_q <= (op_i[3:2] == 2'b00) ? cin_i : 1'b0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + CW'(1);
      sr_q  <= res_next;
      if (is_arith) carry_q <= slice_cout_i;
      // Visible outputs move only here so they hold through IDLE and the next run.
      if (last_bit) begin
        result_o <= res_next;
        zero_o   <= ~|res_next;
        case (op_q[3:2])
          2'b00:   cout_o <= slice_cout_i;
          2'b10:   cout_o <= a_q[0];
          2'b11:   cout_o <= a_q[WIDTH-1];
          default: cout_o <= 1'b0;
        endcase
`ifdef ALU_SERIAL_OVF_EN
        ovf_o <= is_arith & (carry_q ^ slice_cout_i);
`endif
      end
    end
  end

endmodule

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Sequencer that runs a full WIDTH-bit ALU operation through the single 1-bit ALU slice, one bit per clock, LSB first. It sits directly around the slice. Upstream, it latches the operands and opcode and drives the slice's `a_i`, `b_i`, `cin_i` and `sel_i` for the current bit. Downstream, it captures the slice's `f_o` and `cout_o`, ripples the carry through a register, and assembles the WIDTH-bit result, carry-out and zero flag for the datapath.

## Interface
- `WIDTH`, default 32: operand and result width in bits; must be ≥ 2.
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `start_i`  in  1: begin an operation; sampled only in IDLE.
- `op_i`  in  4: opcode, same encoding as the slice `sel_i`.
- `a_i`, `b_i`  in  WIDTH: operands, latched on an accepted start.
- `cin_i`  in  1: initial carry-in for arithmetic ops, latched on an accepted start.
- `busy_o`  out  1: operation in progress.
- `done_o`  out  1: one-cycle pulse; result and flags are valid.
- `result_o`  out  WIDTH: result, held until the next accepted start.
- `cout_o`  out  1: final carry (arithmetic) or shifted-out bit (shifts).
- `zero_o`  out  1: `result_o == 0`.
- `slice_a_o`, `slice_b_o`, `slice_cin_o`  out  1 each: drive the slice `a_i`, `b_i`, `cin_i`.
- `slice_sel_o`  out  4: drives the slice `sel_i`.
- `slice_f_i`, `slice_cout_i`  in  1 each: from the slice `f_o`, `cout_o`.

## Operation
- Slice encoding, `sel[3:2]`:
  - 00 arithmetic, selected by `sel[1:0]`: 00 A+cin, 01 A+B+cin, 10 A+~B+cin, 11 A−1+cin.
  - 01 logic, selected by `sel[1:0]`: 00 AND, 01 OR, 10 XOR, 11 NOT A.
  - 10 SHR and 11 SHL: the slice cannot do these bit-serially, so this block implements them.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start_i`: latch A, B, op; set bit count `cnt` = 0; set the carry register to `cin_i` for arithmetic, 0 otherwise.
  - RUN: for bit `cnt`, drive the slice and sample `slice_f_i` in the same cycle. Shift the sampled bit into the MSB of the result register; the result register shifts right. Arithmetic ops also load `slice_cout_i` into the carry register. RUN → DONE when `cnt == WIDTH−1`.
  - DONE: `done_o` = 1 for this cycle only, then DONE → IDLE.
- Slice drive, arithmetic and logic ops: `slice_sel_o` = op; `slice_a_o` = A[cnt]; `slice_b_o` = B[cnt]; `slice_cin_o` = carry register for arithmetic ops, 0 for logic ops.
- Slice drive, shift ops: `slice_sel_o` = 4'b0000 (transfer A); `slice_cin_o` = 0; `slice_b_o` = 0; `op[1:0]` is ignored.
  - SHR: `slice_a_o` = A[cnt+1], or 0 when `cnt == WIDTH−1`.
  - SHL: `slice_a_o` = A[cnt−1], or 0 when `cnt == 0`.
- `cout_o`:
  - arithmetic: carry out of bit WIDTH−1;
  - logic: 0;
  - SHR: A[0];
  - SHL: A[WIDTH−1].
- `start_i` is ignored in RUN and DONE. It is not queued.
- `result_o`, `cout_o` and `zero_o` change only at the RUN→DONE transition. They hold their values through IDLE.

## Timing
- Reset values: `busy_o` 0, `done_o` 0, `result_o` 0, `cout_o` 0, `zero_o` 1, all `slice_*_o` 0; state is IDLE.
- Reset asserted mid-operation aborts immediately to the reset values. No `done_o` is produced.
- Cycle timeline with `start_i` sampled at edge 0:
  - `busy_o` rises after edge 0.
  - Bits 0..WIDTH−1 are processed in cycles 1..WIDTH.
  - `done_o` is high in cycle WIDTH+1, when `busy_o` is 0.
  - Latency is WIDTH+1 cycles, from start to done.
- A new start is accepted in the cycle after `done_o` at the earliest. Back-to-back throughput is one operation per WIDTH+2 cycles.
- The slice path is combinational within one cycle: registered `slice_*_o` → slice → `slice_f_i`/`slice_cout_i` → register.

## Configuration
- `ALU_SERIAL_OVF_EN` defined:
  - Adds output `ovf_o` (1 bit, reset 0), valid with `done_o` and held like `result_o`.
  - For arithmetic ops, `ovf_o` = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1. For all other ops it is 0.
  - The carry into the MSB is captured during bit WIDTH−1.
- Macro undefined: the `ovf_o` port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8 with a behavioural slice model.

- op 0001, A=0x7F, B=0x01, cin=0 → `done_o` exactly 9 cycles after start; result 0x80, cout 0, zero 0, `ovf_o` 1 (when enabled).
- op 0010, A=0x05, B=0x07, cin=1 → result 0xFE, cout 0; then A=0x07, B=0x07, cin=1 → result 0x00, cout 1, zero 1.
- op 0110 (XOR), A=0xA5, B=0xFF → result 0x5A, cout 0. Op 1000 (SHR), A=0x81 → result 0x40, cout 1. Op 1100 (SHL), A=0x81 → result 0x02, cout 1.
- `start_i` pulsed again in RUN with different operands → ignored; first result delivered unchanged with a single `done_o` pulse.
- `rst_ni` low at bit 4 of a running op → immediately busy 0, result 0, zero 1, no `done_o`; a fresh op after release completes correctly.
- Back-to-back: start in the cycle after `done_o` → accepted; `result_o` holds the previous value until the new `done_o`.
